rat_uart_tx_port: RTL and testbench

- Output-side I/O peripheral directly downstream of the RAT MCU; consumes the MCU's PORT_ID / OUT_PORT / IO_STRB write bus.
- Bytes written to the data port enter a small FIFO and are serialized as 8N1 UART frames on TX.
- A status byte is driven toward the top-level IN_PORT mux so firmware can poll FIFO and transmitter state.

---
 rtl/rat_io_pkg.sv | 36 +++
 rtl/rat_uart_tx_port_if.sv | 32 +++
 rtl/rat_byte_fifo.sv | 66 ++++++
 rtl/rat_uart_tx_port.sv | 137 +++++++++++++
 tb/tb_rat_uart_tx_port.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rat_io_pkg.sv
// rtl/rat_io_pkg.sv - shared port IDs, status bit map and TX FSM states for RAT I/O ports
package rat_io_pkg;

    localparam logic [7:0] DEF_DATA_PORT_ID   = 8'h40;
    localparam logic [7:0] DEF_STATUS_PORT_ID = 8'h41;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Count occupies the upper nibble; flags sit at their named bit indices.
    function automatic logic [7:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       busy,
        input logic       ovf,
        input logic [3:0] count
    );
        logic [7:0] s;
        s           = {count, 4'b0000};
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        s[ST_BUSY]  = busy;
        s[ST_OVF]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/rat_uart_tx_port_if.sv
// rtl/rat_uart_tx_port_if.sv - MCU write bus plus status/serial outputs of the UART TX port
interface rat_uart_tx_port_if;

    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] STATUS_OUT;
    logic       STATUS_SEL;
    logic       TX;
    logic       TX_BUSY;

    modport master (
        output PORT_ID,
        output OUT_PORT,
        output IO_STRB,
        input  STATUS_OUT,
        input  STATUS_SEL,
        input  TX,
        input  TX_BUSY
    );

    modport slave (
        input  PORT_ID,
        input  OUT_PORT,
        input  IO_STRB,
        output STATUS_OUT,
        output STATUS_SEL,
        output TX,
        output TX_BUSY
    );

endinterface

// File: rtl/rat_byte_fifo.sv
// rtl/rat_byte_fifo.sv - show-ahead byte FIFO; a push into a full FIFO is taken only alongside a pop
module rat_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [7:0]             i_din,
    output logic [7:0]             o_dout,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers are exactly AW bits, so power-of-two depth makes them wrap by themselves.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;

endmodule

// File: rtl/rat_uart_tx_port.sv
// rtl/rat_uart_tx_port.sv - RAT MCU output port: buffered 8N1 UART transmitter with pollable status
module rat_uart_tx_port
    import rat_io_pkg::*;
#(
    parameter int         CLKS_PER_BIT   = 868,
    parameter logic [7:0] DATA_PORT_ID   = DEF_DATA_PORT_ID,
    parameter logic [7:0] STATUS_PORT_ID = DEF_STATUS_PORT_ID,
    parameter int         FIFO_DEPTH     = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    rat_uart_tx_port_if.slave    bus
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int AW     = $clog2(FIFO_DEPTH);

    tx_state_t         r_state;
    logic              r_tx;
    logic [7:0]        r_shift;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic              r_ovf;

    logic              w_wr_data;
    logic              w_wr_ctrl;
    logic              w_baud_end;
    logic              w_pop;
    logic [7:0]        w_head;
    logic              w_empty;
    logic              w_full;
    logic [AW:0]       w_count;

    assign w_wr_data  = bus.IO_STRB && (bus.PORT_ID == DATA_PORT_ID);
    assign w_wr_ctrl  = bus.IO_STRB && (bus.PORT_ID == STATUS_PORT_ID) && bus.OUT_PORT[0];
    assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    // The FSM takes the next byte either from idle or right at the end of a stop bit.
    assign w_pop = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));

    rat_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_push  (w_wr_data),
        .i_pop   (w_pop),
        .i_din   (bus.OUT_PORT),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // Set has priority over clear so a dropped byte is never hidden.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ovf <= 1'b0;
        end else if (w_wr_data && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_wr_ctrl) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_shift   <= 8'h00;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_tx      <= r_shift[0];
                        r_bit_idx <= 3'd0;
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    // r_shift[0] is always the bit on the line; shifting exposes the next one.
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.TX         = r_tx;
    assign bus.TX_BUSY    = !w_empty || (r_state != IDLE);
    assign bus.STATUS_SEL = (bus.PORT_ID == STATUS_PORT_ID);
    assign bus.STATUS_OUT = pack_status(w_empty, w_full, (r_state != IDLE), r_ovf, 4'(w_count));

endmodule

// File: tb/tb_rat_uart_tx_port.sv
// tb/tb_rat_uart_tx_port.sv - randomized self-checking bench against a frame-level UART port model
module tb_rat_uart_tx_port;

    localparam int         CPB    = 4;
    localparam int         DEPTH  = 8;
    localparam logic [7:0] P_DATA = 8'h40;
    localparam logic [7:0] P_STAT = 8'h41;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rat_uart_tx_port_if bus ();

    rat_uart_tx_port #(
        .CLKS_PER_BIT   (CPB),
        .DATA_PORT_ID   (P_DATA),
        .STATUS_PORT_ID (P_STAT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a byte queue plus the position inside the frame currently on the line.
    logic [7:0] m_q[$];
    bit         m_active;
    int         m_t;
    logic [7:0] m_cur;
    bit         m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_t      = 0;
        m_cur    = 8'h00;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (!m_active) begin
                if (m_q.size() > 0) begin
                    m_cur    = m_q.pop_front();
                    m_active = 1'b1;
                    m_t      = 0;
                end
            end else if (m_t == 10 * CPB - 1) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_t   = 0;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_t++;
            end
            if (bus.IO_STRB && bus.PORT_ID == P_DATA) begin
                if (m_q.size() < DEPTH) m_q.push_back(bus.OUT_PORT);
                else m_ovf = 1'b1;
            end else if (bus.IO_STRB && bus.PORT_ID == P_STAT && bus.OUT_PORT[0]) begin
                m_ovf = 1'b0;
            end
        end
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    function automatic logic [7:0] exp_status();
        logic [3:0] c;
        c = 4'(m_q.size());
        return {c, m_ovf, m_active, (m_q.size() == DEPTH), (m_q.size() == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("tx", bus.TX, exp_tx());
        check_eq("busy", bus.TX_BUSY, (m_active || m_q.size() != 0));
        check_eq("status", bus.STATUS_OUT, exp_status());
        check_eq("sel", bus.STATUS_SEL, (bus.PORT_ID == P_STAT));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [7:0] pid, input logic [7:0] data);
        bus.PORT_ID  = pid;
        bus.OUT_PORT = data;
        bus.IO_STRB  = 1'b1;
        tick();
        bus.IO_STRB  = 1'b0;
    endtask

    initial begin
        int r;
        bus.PORT_ID  = 8'h00;
        bus.OUT_PORT = 8'h00;
        bus.IO_STRB  = 1'b0;
        model_reset();
        idle(3);
        rst_n = 1'b1;
        check_eq("rst_tx", bus.TX, 1'b1);
        check_eq("rst_busy", bus.TX_BUSY, 1'b0);
        check_eq("rst_status", bus.STATUS_OUT, 8'h01);
        idle(2);

        bus_write(P_DATA, 8'hA5);
        idle(45);

        bus_write(P_DATA, 8'h01);
        bus_write(P_DATA, 8'h02);
        bus_write(P_DATA, 8'h03);
        idle(125);

        bus_write(P_DATA, 8'h10);
        for (int i = 0; i < 10; i++) bus_write(P_DATA, 8'h20 + 8'(i));
        bus.PORT_ID = P_STAT;
        #1;
        check_eq("status_full_ovf", bus.STATUS_OUT, 8'h8E);
        check_eq("status_sel", bus.STATUS_SEL, 1'b1);
        bus_write(P_STAT, 8'h01);
        check_eq("ovf_clear", bus.STATUS_OUT[3], 1'b0);
        bus_write(P_STAT, 8'h00);
        check_eq("ovf_still_clear", bus.STATUS_OUT[3], 1'b0);
        bus_write(P_DATA, 8'h77);
        bus_write(P_DATA, 8'h78);
        check_eq("ovf_reset_by_drop", bus.STATUS_OUT[3], 1'b1);
        bus_write(P_STAT, 8'hFE);
        check_eq("ovf_ignore_bit1", bus.STATUS_OUT[3], 1'b1);
        idle(400);

        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            bus.OUT_PORT = 8'($urandom);
            if (r < 6) begin
                bus.PORT_ID = P_DATA;
                bus.IO_STRB = 1'b1;
            end else if (r < 8) begin
                bus.PORT_ID = P_STAT;
                bus.IO_STRB = 1'b1;
            end else if (r < 10) begin
                bus.PORT_ID = 8'($urandom_range(0, 63));
                bus.IO_STRB = 1'b1;
            end else begin
                bus.PORT_ID = (r < 40) ? P_STAT : ((r < 70) ? P_DATA : 8'($urandom));
                bus.IO_STRB = 1'b0;
            end
            tick();
            bus.IO_STRB = 1'b0;
        end
        idle(400);

        bus_write(P_DATA, 8'hC3);
        idle(15);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_tx", bus.TX, 1'b1);
        check_eq("async_rst_busy", bus.TX_BUSY, 1'b0);
        check_eq("async_rst_status", bus.STATUS_OUT, 8'h01);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        bus_write(P_DATA, 8'h55);
        idle(45);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
